// File: rtl/byte_serial_adder32.sv
`default_nettype none
// ============================================================================
// Module   : byte_serial_adder32
// Brief    : Wide adder that processes one byte per clock through a single
//            8-bit add-with-carry slice, registering the carry between bytes.
// Revision : 1.0 - initial release
// ============================================================================
module byte_serial_adder32 #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [IDXW-1:0]   idx;
    logic              c;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;

    logic [7:0]        a_byte;
    logic [7:0]        b_byte;
    logic [8:0]        byte_res;

    // Operands are viewed as byte lanes so the active lane is a plain index.
    logic [7:0]        a_lane [NBYTES];
    logic [7:0]        b_lane [NBYTES];

    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
        assign a_lane[i] = a_reg[8*i +: 8];
        assign b_lane[i] = b_reg[8*i +: 8];
    end

    always_comb begin
        a_byte   = a_lane[idx];
        b_byte   = b_lane[idx];
        byte_res = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, c};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            c     <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        c     <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum[{idx, 3'b000} +: 8] <= byte_res[7:0];
                    c                       <= byte_res[8];
                    if (idx == LAST_IDX) begin
                        cout  <= byte_res[8];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_byte_serial_adder32.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_serial_adder32
// Brief    : Directed and random checks of the byte-serial adder (NBYTES=4,1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_serial_adder32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout;
    logic [31:0] sum;

    logic        start1 = 1'b0;
    logic [7:0]  a1 = '0;
    logic [7:0]  b1 = '0;
    logic        cin1 = 1'b0;
    logic        busy1, done1, cout1;
    logic [7:0]  sum1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    byte_serial_adder32 #(.NBYTES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    byte_serial_adder32 #(.NBYTES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One addition on the 4-byte instance; optionally scrambles inputs mid-run.
    task automatic add4(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                        input logic [31:0] exp_sum, input logic exp_cout,
                        input bit scramble, input string tag);
        int  busy_cycles;
        bit  seen;
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
        check({tag, "_sum_cleared"}, {32'd0, sum}, 64'd0);
        if (scramble) begin
            a = ~av; b = av ^ bv; cin = ~cv;
        end
        busy_cycles = 1;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
        end
        check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
        check({tag, "_busy_len"}, 64'(busy_cycles), 64'd4);
        check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_sum"}, {32'd0, sum}, {32'd0, exp_sum});
        check({tag, "_cout"}, {63'd0, cout}, {63'd0, exp_cout});
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_sum_hold"}, {32'd0, sum}, {32'd0, exp_sum});
    endtask

    task automatic add1(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic [7:0] exp_sum, input logic exp_cout, input string tag);
        @(negedge clk);
        a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check({tag, "_busy"}, {63'd0, busy1}, 64'd1);
        @(posedge clk); #1;
        check({tag, "_done"}, {63'd0, done1}, 64'd1);
        check({tag, "_busy_off"}, {63'd0, busy1}, 64'd0);
        check({tag, "_sum"}, {56'd0, sum1}, {56'd0, exp_sum});
        check({tag, "_cout"}, {63'd0, cout1}, {63'd0, exp_cout});
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {63'd0, done1}, 64'd0);
    endtask

    initial begin
        logic [32:0] ref4;
        logic [8:0]  ref1;
        logic [31:0] ra, rb;
        logic        rc;
        int          rises [8];
        int          nr;
        bit          prevb;
        bit          seen_done;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_sum", {32'd0, sum}, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        add4(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "v1");
        add4(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "v2");
        add4(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "v3");
        add4(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, "v4");
        add4(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 32'hDFD1_0457, 1'b0, 1'b1, "scramble");

        // start held high: acceptances every NBYTES+2 = 6 edges
        @(negedge clk);
        a = 32'h0F0F_0F0F; b = 32'h1010_1010; cin = 1'b1; start = 1'b1;
        nr = 0;
        prevb = 1'b0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (busy && !prevb && nr < 8) begin
                rises[nr] = e;
                nr++;
            end
            if (done) check("held_sum", {32'd0, sum}, 64'h1F1F_1F20);
            prevb = busy;
        end
        check("held_count", {63'd0, (nr >= 3)}, 64'd1);
        if (nr >= 3) begin
            check("held_period1", 64'(rises[1] - rises[0]), 64'd6);
            check("held_period2", 64'(rises[2] - rises[1]), 64'd6);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);

        // reset asserted while idx = 2
        @(negedge clk);
        a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        check("mid_rst_sum", {32'd0, sum}, 64'd0);
        check("mid_rst_cout", {63'd0, cout}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("post_rst_quiet", {63'd0, seen_done}, 64'd0);
        add4(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, "after_rst");

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            ref4 = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            add4(ra, rb, rc, ref4[31:0], ref4[32], (i % 4) == 0, "rnd4");
        end

        add1(8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, "n1_dir");
        add1(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0, "n1_dir2");
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            ref1 = {1'b0, ra[7:0]} + {1'b0, rb[7:0]} + {8'd0, rc};
            add1(ra[7:0], rb[7:0], rc, ref1[7:0], ref1[8], "rnd1");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
